instr_encoder: RTL

Sequential MIPS instruction encoder for the single-cycle CPU test infrastructure. Accepts one assembler-level request per handshake and packs the mnemonic and its operand fields into a 32-bit MIPS word. The block then writes that word into instruction memory at an auto-incrementing address. It is the inverse of the control decoder: it produces exactly the op and funct encodings that the decoder consumes, and it is the bench/boot-time program loader.

---
 rtl/instr_encoder.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder / program loader: packs one request per handshake into a 32-bit word
// and writes it to instruction memory at an auto-incrementing address. Optional macro: ENC_NOP_PAD_EN.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              ovf
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [4:0] M_ADD   = 5'd0;
  localparam logic [4:0] M_ADDU  = 5'd1;
  localparam logic [4:0] M_SUB   = 5'd2;
  localparam logic [4:0] M_SUBU  = 5'd3;
  localparam logic [4:0] M_AND   = 5'd4;
  localparam logic [4:0] M_OR    = 5'd5;
  localparam logic [4:0] M_XOR   = 5'd6;
  localparam logic [4:0] M_NOR   = 5'd7;
  localparam logic [4:0] M_SLT   = 5'd8;
  localparam logic [4:0] M_SLTU  = 5'd9;
  localparam logic [4:0] M_SLL   = 5'd10;
  localparam logic [4:0] M_SRL   = 5'd11;
  localparam logic [4:0] M_SRA   = 5'd12;
  localparam logic [4:0] M_ADDI  = 5'd13;
  localparam logic [4:0] M_ADDIU = 5'd14;
  localparam logic [4:0] M_SLTI  = 5'd15;
  localparam logic [4:0] M_SLTIU = 5'd16;
  localparam logic [4:0] M_ANDI  = 5'd17;
  localparam logic [4:0] M_ORI   = 5'd18;
  localparam logic [4:0] M_XORI  = 5'd19;
  localparam logic [4:0] M_LUI   = 5'd20;
  localparam logic [4:0] M_LW    = 5'd21;
  localparam logic [4:0] M_SW    = 5'd22;
  localparam logic [4:0] M_BEQ   = 5'd23;
  localparam logic [4:0] M_BNE   = 5'd24;
  localparam logic [4:0] M_J     = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
`ifdef ENC_NOP_PAD_EN
    S_PAD  = 2'd2,
`endif
    S_FULL = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   ptr_reg, ptr_next, ptr_inc;
  logic              we_reg, we_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic              ready_reg, ready_next;
  logic              accept;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              is_r, is_shift, is_j;
  logic [5:0]        funct, op;
  logic [4:0]        rs_f;

`ifdef ENC_NOP_PAD_EN
  logic              pad_reg, pad_next;
  logic              ovf_reg, ovf_next;
  logic              enc_branch;
  assign enc_branch = (in_mnem == M_BEQ) || (in_mnem == M_BNE) || (in_mnem == M_J);
`endif

  // Field packing straight from the request; the result is only ever captured into wdata_reg.
  always_comb begin
    funct     = 6'h00;
    op        = 6'h00;
    is_r      = 1'b0;
    is_shift  = 1'b0;
    is_j      = 1'b0;
    enc_legal = 1'b1;
    rs_f      = in_rs;
    case (in_mnem)
      M_ADD:   begin is_r = 1'b1; funct = 6'h20; end
      M_ADDU:  begin is_r = 1'b1; funct = 6'h21; end
      M_SUB:   begin is_r = 1'b1; funct = 6'h22; end
      M_SUBU:  begin is_r = 1'b1; funct = 6'h23; end
      M_AND:   begin is_r = 1'b1; funct = 6'h24; end
      M_OR:    begin is_r = 1'b1; funct = 6'h25; end
      M_XOR:   begin is_r = 1'b1; funct = 6'h26; end
      M_NOR:   begin is_r = 1'b1; funct = 6'h27; end
      M_SLT:   begin is_r = 1'b1; funct = 6'h2A; end
      M_SLTU:  begin is_r = 1'b1; funct = 6'h2B; end
      M_SLL:   begin is_r = 1'b1; is_shift = 1'b1; funct = 6'h00; end
      M_SRL:   begin is_r = 1'b1; is_shift = 1'b1; funct = 6'h02; end
      M_SRA:   begin is_r = 1'b1; is_shift = 1'b1; funct = 6'h03; end
      M_ADDI:  op = 6'h08;
      M_ADDIU: op = 6'h09;
      M_SLTI:  op = 6'h0A;
      M_SLTIU: op = 6'h0B;
      M_ANDI:  op = 6'h0C;
      M_ORI:   op = 6'h0D;
      M_XORI:  op = 6'h0E;
      M_LUI:   begin op = 6'h0F; rs_f = 5'd0; end
      M_LW:    op = 6'h23;
      M_SW:    op = 6'h2B;
      M_BEQ:   op = 6'h04;
      M_BNE:   op = 6'h05;
      M_J:     is_j = 1'b1;
      default: enc_legal = 1'b0;
    endcase
    if (is_shift)
      rs_f = 5'd0;
    if (is_j)
      enc_word = {6'b000010, in_target};
    else if (is_r)
      enc_word = {6'b000000, rs_f, in_rt, in_rd, (is_shift ? in_shamt : 5'd0), funct};
    else
      enc_word = {op, rs_f, in_rt, in_imm};
  end

  assign accept  = in_valid && ready_reg && !clear;
  assign ptr_inc = ptr_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    we_next    = 1'b0;
    wdata_next = wdata_reg;
    err_next   = err_reg;
`ifdef ENC_NOP_PAD_EN
    pad_next   = pad_reg;
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (enc_legal) begin
            state_next = S_WR;
            we_next    = 1'b1;
            wdata_next = enc_word;
`ifdef ENC_NOP_PAD_EN
            pad_next   = enc_branch;
`endif
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_WR: begin
        ptr_next = ptr_inc;
        if (ptr_inc == DEPTH_C) begin
          state_next = S_FULL;
`ifdef ENC_NOP_PAD_EN
          // A branch in the last slot has nowhere to put its delay-slot NOP.
          if (pad_reg)
            ovf_next = 1'b1;
          pad_next = 1'b0;
        end else if (pad_reg) begin
          state_next = S_PAD;
          we_next    = 1'b1;
          wdata_next = 32'h0000_0000;
          pad_next   = 1'b0;
`endif
        end else if (accept && enc_legal) begin
          state_next = S_WR;
          we_next    = 1'b1;
          wdata_next = enc_word;
`ifdef ENC_NOP_PAD_EN
          pad_next   = enc_branch;
`endif
        end else begin
          state_next = S_IDLE;
          if (accept)
            err_next = 1'b1;
        end
      end
`ifdef ENC_NOP_PAD_EN
      S_PAD: begin
        ptr_next   = ptr_inc;
        state_next = (ptr_inc == DEPTH_C) ? S_FULL : S_IDLE;
      end
`endif
      S_FULL: state_next = S_FULL;
      default: state_next = S_IDLE;
    endcase
    // The write being presented this cycle still commits; clear only affects what follows.
    if (clear) begin
      state_next = S_IDLE;
      ptr_next   = '0;
      err_next   = 1'b0;
      we_next    = 1'b0;
`ifdef ENC_NOP_PAD_EN
      pad_next   = 1'b0;
      ovf_next   = 1'b0;
`endif
    end
    ready_next = (state_next == S_IDLE) ||
                 ((state_next == S_WR) && ((ptr_next + 1'b1) != DEPTH_C)
`ifdef ENC_NOP_PAD_EN
                  && !pad_next
`endif
                 );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= 32'h0000_0000;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
`ifdef ENC_NOP_PAD_EN
      pad_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      ready_reg <= ready_next;
`ifdef ENC_NOP_PAD_EN
      pad_reg   <= pad_next;
      ovf_reg   <= ovf_next;
`endif
    end
  end

  assign in_ready = ready_reg;
  assign im_we    = we_reg;
  assign im_addr  = ptr_reg[ADDR_W-1:0];
  assign im_wdata = wdata_reg;
  assign count    = ptr_reg;
  assign full     = (ptr_reg == DEPTH_C);
  assign err      = err_reg;
`ifdef ENC_NOP_PAD_EN
  assign ovf      = ovf_reg;
`else
  assign ovf      = 1'b0;
`endif

endmodule
